// File: rtl/dec_pkg.sv
// dec_pkg: shared widths and FSM state type for the 3-to-8 hold decoder.
package dec_pkg;
    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } dec_state_t;
endpackage

// File: rtl/dec3to8_comb.sv
// dec3to8_comb: combinational binary code to one-hot line.
module dec3to8_comb
    import dec_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  y
);

    always_comb begin
        y = OUT_W'(1) << code;
    end

endmodule

// File: rtl/dec3to8_hold.sv
// dec3to8_hold: handshaked 3-to-8 decoder holding y for HOLD_CYCLES.
// Optional even-parity check on code enabled by DEC_PARITY_EN.
module dec3to8_hold
    import dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code,
    input  logic              code_par,
    input  logic              err_clr,
    output logic [OUT_W-1:0]  y,
    output logic              out_valid,
    output logic              err
);

    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

    dec_state_t       state_q, state_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic [OUT_W-1:0] onehot;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             accept;
    logic             par_bad;

    dec3to8_comb u_comb (
        .code (code),
        .y    (onehot)
    );

    // rst_n gates in_ready so no code is offered during reset.
    assign in_ready = rst_n && (state_q == ST_IDLE) && en;
    assign accept   = in_valid && in_ready;

`ifdef DEC_PARITY_EN
    assign par_bad = ^{code, code_par};

    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (accept && par_bad) begin
            err_d = 1'b1;
        end
    end
`else
    assign par_bad = 1'b0;

    always_comb begin
        err_d = 1'b0 & (code_par ^ err_clr);
    end
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !par_bad) begin
                    y_d     = onehot;
                    cnt_d   = HOLD_INIT;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!en || (cnt_q == '0)) begin
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                y_d     = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign y         = y_q;
    assign out_valid = (state_q == ST_HOLD);
    assign err       = err_q;

endmodule

// File: tb/tb_dec3to8_hold.sv
// tb_dec3to8_hold: checks HOLD_CYCLES=4 and HOLD_CYCLES=1 instances
// against a per-cycle behavioural model plus directed literal checks.
module tb_dec3to8_hold;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [2:0] code;
    logic       code_par;
    logic       err_clr;

    logic [7:0] y4, y1;
    logic       ov4, ov1;
    logic       rdy4, rdy1;
    logic       err4, err1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit run    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dec3to8_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (rdy4),
        .code      (code),
        .code_par  (code_par),
        .err_clr   (err_clr),
        .y         (y4),
        .out_valid (ov4),
        .err       (err4)
    );

    dec3to8_hold #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (rdy1),
        .code      (code),
        .code_par  (code_par),
        .err_clr   (err_clr),
        .y         (y1),
        .out_valid (ov1),
        .err       (err1)
    );

    // Model: per unit, whether a pulse is showing, its code,
    // how many cycles it has been shown, and the sticky error.
    int         hc[2] = '{4, 1};
    logic       ev[2] = '{1'b0, 1'b0};
    logic [2:0] ec[2] = '{3'd0, 3'd0};
    int         sh[2] = '{0, 0};
    logic       ee[2] = '{1'b0, 1'b0};
    logic [7:0] sby0, sby1;

    dec3to8_comb sb0 (.code(ec[0]), .y(sby0));
    dec3to8_comb sb1 (.code(ec[1]), .y(sby1));

    logic [2:0] pc;
    logic [7:0] pcy;
    logic [7:0] lit[8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                           8'h10, 8'h20, 8'h40, 8'h80};

    dec3to8_comb pin (.code(pc), .y(pcy));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ev[k] = 1'b0;
                sh[k] = 0;
                ee[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic bad;
                logic nerr;
                bad  = 1'b0;
                nerr = ee[k];
`ifdef DEC_PARITY_EN
                bad = ^{code, code_par};
                if (err_clr) nerr = 1'b0;
`endif
                if (ev[k]) begin
                    if (!en || sh[k] == hc[k]) ev[k] = 1'b0;
                    else sh[k] = sh[k] + 1;
                end else if (en && in_valid) begin
                    if (bad) begin
                        nerr = 1'b1;
                    end else begin
                        ev[k] = 1'b1;
                        ec[k] = code;
                        sh[k] = 1;
                    end
                end
                ee[k] = nerr;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%0h exp=%0h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic cmp(input int k, input logic [7:0] y,
                       input logic ov, input logic rdy,
                       input logic er);
        logic [7:0] ey;
        ey = ev[k] ? ((k == 0) ? sby0 : sby1) : 8'h00;
        chk($sformatf("u%0d_y", k), 32'(y), 32'(ey));
        chk($sformatf("u%0d_ov", k), 32'(ov), 32'(ev[k]));
        chk($sformatf("u%0d_rdy", k), 32'(rdy),
            32'(rst_n && en && !ev[k]));
        chk($sformatf("u%0d_err", k), 32'(er), 32'(ee[k]));
        chk($sformatf("u%0d_1hot", k),
            32'($countones(y) <= 1), 32'd1);
    endtask

    always @(negedge clk) begin
        if (run) begin
            cmp(0, y4, ov4, rdy4, err4);
            cmp(1, y1, ov1, rdy1, err1);
        end
    end

    task automatic set_code(input logic [2:0] c, input logic bad);
        code     = c;
        code_par = (^c) ^ bad;
    endtask

    // Returns at posedge+1 after the accepting edge of unit k.
    task automatic wait_acc(input int k, output int at);
        logic got;
        got = 1'b0;
        at  = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((k == 0) ? rdy4 : rdy1) begin
                @(posedge clk);
                #1;
                at  = cyc;
                got = 1'b1;
            end
        end
        if (!got) chk("acc_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t, tp;
        rst_n    = 1'b1;
        en       = 1'b1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        set_code(3'd0, 1'b0);
        pc       = 3'd0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_y", 32'(y4), 32'h0);
        chk("rst_ov", 32'(ov4), 32'h0);
        chk("rst_rdy", 32'(rdy4), 32'h0);
        chk("rst_err", 32'(err4), 32'h0);
        for (int i = 0; i < 8; i++) begin
            pc = 3'(i);
            #1 chk("comb_lit", 32'(pcy), 32'(lit[i]));
        end
        run = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;

        in_valid = 1'b1;
        tp = -1;
        for (int c = 0; c < 8; c++) begin
            set_code(3'(c), 1'b0);
            wait_acc(0, t);
            chk("seq_y", 32'(y4), 32'(lit[c]));
            if (tp >= 0) chk("seq_space", 32'(t - tp), 32'd5);
            tp = t;
        end

        set_code(3'd5, 1'b0);
        wait_acc(0, t);
        in_valid = 1'b0;
        chk("abort_y1", 32'(y4), 32'h20);
        @(posedge clk); #1;
        chk("abort_y2", 32'(y4), 32'h20);
        en = 1'b0;
        @(posedge clk); #1;
        chk("abort_y0", 32'(y4), 32'h00);
        chk("abort_ov", 32'(ov4), 32'h0);
        repeat (2) @(posedge clk);
        #1 chk("abort_rdy0", 32'(rdy4), 32'h0);
        en = 1'b1;
        #1 chk("abort_rdy1", 32'(rdy4), 32'h1);

        set_code(3'd3, 1'b0);
        in_valid = 1'b1;
        wait_acc(0, t);
        in_valid = 1'b0;
        #2 chk("ar_pre_y", 32'(y4), 32'h08);
        rst_n = 1'b0;
        #1;
        chk("ar_y", 32'(y4), 32'h00);
        chk("ar_ov", 32'(ov4), 32'h0);
        chk("ar_rdy", 32'(rdy4), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        set_code(3'd7, 1'b0);
        in_valid = 1'b1;
        wait_acc(1, t);
        chk("h1_y", 32'(y1), 32'h80);
        @(posedge clk); #1;
        chk("h1_y0", 32'(y1), 32'h00);
        chk("h1_rdy", 32'(rdy1), 32'h1);
        @(posedge clk); #1;
        chk("h1_y2", 32'(y1), 32'h80);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);

`ifdef DEC_PARITY_EN
        #2;
        set_code(3'd3, 1'b1);
        in_valid = 1'b1;
        wait_acc(0, t);
        in_valid = 1'b0;
        chk("par_bad_y", 32'(y4), 32'h00);
        chk("par_bad_err", 32'(err4), 32'h1);
        chk("par_bad_rdy", 32'(rdy4), 32'h1);
        set_code(3'd3, 1'b0);
        in_valid = 1'b1;
        wait_acc(0, t);
        in_valid = 1'b0;
        chk("par_ok_y", 32'(y4), 32'h08);
        chk("par_ok_err", 32'(err4), 32'h1);
        repeat (5) @(posedge clk);
        #2 err_clr = 1'b1;
        @(posedge clk); #1;
        chk("par_clr", 32'(err4), 32'h0);
        err_clr = 1'b0;
`endif

        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #2;
            en       = ($urandom_range(0, 9) != 0);
            in_valid = 1'($urandom_range(0, 1));
            set_code(3'($urandom), 1'($urandom_range(0, 15) == 0));
            err_clr  = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk);
        @(negedge clk);
        #1 run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec3to8_hold.md
Name: dec3to8_hold

Overview:
- Sequential 3-to-8 one-hot decoder; inverse of the team's 8-to-3 encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line, registered, for a programmable number of cycles.
- Used to drive LED/digit-select lines and to loop back encoder output in bring-up benches.

Parameters:
- HOLD_CYCLES, 4: cycles each one-hot output stays asserted; legal range 1..255.
- CNT_W, 8: hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable.
- in_valid  in  1  code presented.
- in_ready  out  1  block can accept a code.
- code  in  3  binary code 0..7.
- code_par  in  1  even-parity bit for code; used only with DEC_PARITY_EN.
- err_clr  in  1  clears err; used only with DEC_PARITY_EN.
- y  out  8  registered one-hot output; y[code] set.
- out_valid  out  1  high while y is driven.
- err  out  1  sticky parity error flag.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - state=IDLE, y=8'h00, out_valid=0, cnt=0, err=0.
  - in_ready=0 while rst_n is low; in_ready=en after release.
- in_ready is combinational: in_ready = (state==IDLE) && en.
- Accept event: in_valid && in_ready at a rising edge. code is sampled only at accept.
- IDLE:
  - On accept, the next edge gives y = 8'h01 << code, out_valid=1, cnt=HOLD_CYCLES-1, state=HOLD.
  - Latency from accept edge to y valid: 1 clock.
- HOLD:
  - in_ready=0. If cnt!=0, cnt decrements by 1 and y is held.
  - If cnt==0, the next edge gives y=0, out_valid=0, state=IDLE.
  - Net: y is high for exactly HOLD_CYCLES cycles.
- en low in IDLE: no accept; in_valid may stay high and is held off.
- en low in HOLD: abort. The next edge gives y=0, out_valid=0, state=IDLE. The remaining count is discarded.
- Throughput: minimum accept-to-accept spacing is HOLD_CYCLES+1 cycles (one mandatory IDLE cycle).
- Exactly one bit of y is set whenever out_valid=1. y=0 whenever out_valid=0.
- No illegal codes: all 8 values decode. HOLD_CYCLES=1 gives a single-cycle pulse.
- in_valid dropping without an accept is legal and has no effect.

Optional Feature:
- Macro DEC_PARITY_EN.
- Defined:
  - At accept, check ^{code,code_par}. 1 = mismatch.
  - On mismatch: the handshake still completes. No output pulse; state stays IDLE. err is set on the next edge and stays set.
  - err_clr=1 clears err on the next edge. If a mismatch and err_clr occur in the same cycle, set wins.
- Undefined:
  - code_par and err_clr are ignored; err is tied to 0.
  - Port list is identical in both builds.

Decomposition:
- Package dec_pkg:
  - CODE_W=3, OUT_W=8.
  - typedef enum logic {ST_IDLE, ST_HOLD} dec_state_t.
- One sub-module, dec3to8_comb: purely combinational code-to-one-hot (y = 1<<code). It is reused by the bench scoreboard.
- The FSM, counter, handshake and parity logic live in dec3to8_hold.

Test Plan:
- All codes, HOLD_CYCLES=4, en=1: send code 0..7 back-to-back with in_valid held high.
  - Each y (01,02,04,...,80) is high exactly 4 cycles, 1 cycle after accept.
  - Accepts are spaced 5 cycles apart.
- Abort: code=5 accepted, en dropped on the 2nd HOLD cycle.
  - y=8'h20 for 2 cycles, then 8'h00; in_ready stays 0 until en=1.
- Async reset mid-HOLD: rst_n pulled low between edges while y=8'h08.
  - y=0, out_valid=0, in_ready=0 immediately, with no clock edge needed.
- HOLD_CYCLES=1: code=7 accepted.
  - y=8'h80 for exactly 1 cycle; the next accept is possible 2 cycles after the first.
- DEC_PARITY_EN, code=3, code_par=1 (bad):
  - Handshake completes, y stays 0, err=1.
  - Then a good code=3, code_par=0 gives y=8'h08 while err stays 1.
  - err_clr clears err.
- Random: 1000 random codes with random in_valid/en gaps.
  - The dec3to8_comb scoreboard matches; y is always one-hot or zero.
  - Asserted length always equals HOLD_CYCLES unless aborted.
